// File: rtl/pit_lookup_issuer.sv
// FIB-side initiator for PIT lookups: one lookup per header, then wait for the verdict.
// Hits are forwarded downstream with the PIT entry; misses, timeouts and reserved types are dropped.
module pit_lookup_issuer #(
    parameter int PREFIX_W     = 64,
    parameter int META_W       = 8,
    parameter int ENTRY_W      = 11,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [PREFIX_W-1:0] in_prefix,
    input  logic [META_W-1:0]   in_metadata,
    output logic                in_ready,
    output logic [PREFIX_W-1:0] FIB_to_PIT_prefix,
    output logic [META_W-1:0]   FIB_to_PIT_metadata,
    output logic                prefix_ready,
    input  logic [ENTRY_W-1:0]  table_entry,
    input  logic                pit_in_bit,
    input  logic                rejected,
    input  logic                interest_packet,
    output logic                fwd_valid,
    input  logic                fwd_ready,
    output logic [PREFIX_W-1:0] fwd_prefix,
    output logic [ENTRY_W-1:0]  fwd_entry,
    output logic                fwd_is_interest,
    output logic [15:0]         drop_count,
    output logic                timeout_err
);

    localparam int TMR_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FWD
    } state_t;

    state_t              state_q, state_d;
    logic                live_q;
    logic [PREFIX_W-1:0] pfx_q, pfx_d;
    logic [META_W-1:0]   meta_q, meta_d;
    logic [ENTRY_W-1:0]  entry_q, entry_d;
    logic                intr_q, intr_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [15:0]         drop_q, drop_d;

    logic accept;
    logic rsvd;
    logic in_wait;
    logic timer_last;
    logic drop_evt;

    assign rsvd       = in_metadata[META_W-1];
    assign in_wait    = (state_q == S_WAIT);
    assign timer_last = (timer_q == TMR_LAST);
    assign accept     = in_valid && in_ready;

    // State register; live_q holds in_ready low through the reset cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    // Next-state logic; a verdict is only honoured in WAIT, reject beats hit beats timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && !rsvd) state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (rejected)        state_d = S_IDLE;
                else if (pit_in_bit) state_d = S_FWD;
                else if (timer_last) state_d = S_IDLE;
                else                 state_d = S_WAIT;
            end
            S_FWD: begin
                if (fwd_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state (timeout_err also looks at the silent verdict)
    always_comb begin
        in_ready     = live_q && (state_q == S_IDLE);
        prefix_ready = (state_q == S_ISSUE);
        fwd_valid    = (state_q == S_FWD);
        timeout_err  = in_wait && !rejected && !pit_in_bit && timer_last;
    end

    // Datapath next-state: capture header, run wait timer, latch hit, count drops
    always_comb begin
        pfx_d    = pfx_q;
        meta_d   = meta_q;
        entry_d  = entry_q;
        intr_d   = intr_q;
        timer_d  = timer_q;
        drop_evt = 1'b0;
        if (accept) begin
            pfx_d  = in_prefix;
            meta_d = in_metadata;
            if (rsvd) drop_evt = 1'b1;
        end
        if (state_q == S_ISSUE) timer_d = '0;
        if (in_wait) begin
            timer_d = timer_q + 1'b1;
            if (rejected) begin
                drop_evt = 1'b1;
            end else if (pit_in_bit) begin
                entry_d = table_entry;
                intr_d  = interest_packet;
            end else if (timer_last) begin
                drop_evt = 1'b1;
            end
        end
        drop_d = drop_q;
        if (drop_evt && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            pfx_q   <= '0;
            meta_q  <= '0;
            entry_q <= '0;
            intr_q  <= 1'b0;
            timer_q <= '0;
            drop_q  <= '0;
        end else begin
            pfx_q   <= pfx_d;
            meta_q  <= meta_d;
            entry_q <= entry_d;
            intr_q  <= intr_d;
            timer_q <= timer_d;
            drop_q  <= drop_d;
        end
    end

    assign FIB_to_PIT_prefix   = pfx_q;
    assign FIB_to_PIT_metadata = meta_q;
    assign fwd_prefix          = pfx_q;
    assign fwd_entry           = entry_q;
    assign fwd_is_interest     = intr_q;
    assign drop_count          = drop_q;

endmodule

// File: tb/tb_pit_lookup_issuer.sv
// Bench for pit_lookup_issuer: directed cases plus random packets,
// with forwarded packets checked from a scoreboard queue by a monitor.
module tb_pit_lookup_issuer;

    localparam int PW = 64;
    localparam int MW = 8;
    localparam int EW = 11;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_prefix = '0;
    logic [MW-1:0] in_metadata = '0;
    logic          in_ready;
    logic [PW-1:0] FIB_to_PIT_prefix;
    logic [MW-1:0] FIB_to_PIT_metadata;
    logic          prefix_ready;
    logic [EW-1:0] table_entry = '0;
    logic          pit_in_bit = 1'b0;
    logic          rejected = 1'b0;
    logic          interest_packet = 1'b0;
    logic          fwd_valid;
    logic          fwd_ready = 1'b1;
    logic [PW-1:0] fwd_prefix;
    logic [EW-1:0] fwd_entry;
    logic          fwd_is_interest;
    logic [15:0]   drop_count;
    logic          timeout_err;

    pit_lookup_issuer #(
        .PREFIX_W(PW), .META_W(MW), .ENTRY_W(EW), .RESP_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_prefix(in_prefix),
        .in_metadata(in_metadata), .in_ready(in_ready),
        .FIB_to_PIT_prefix(FIB_to_PIT_prefix),
        .FIB_to_PIT_metadata(FIB_to_PIT_metadata),
        .prefix_ready(prefix_ready),
        .table_entry(table_entry), .pit_in_bit(pit_in_bit),
        .rejected(rejected), .interest_packet(interest_packet),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
        .fwd_prefix(fwd_prefix), .fwd_entry(fwd_entry),
        .fwd_is_interest(fwd_is_interest),
        .drop_count(drop_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] p;
        logic [EW-1:0] e;
        logic          i;
    } fwd_t;

    fwd_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_drops = 0;
    bit   rand_rdy = 0;
    bit   mon_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void note_drop();
        if (exp_drops < 65535) exp_drops++;
    endfunction

    // One packet through the issuer, acting as the PIT with a verdict
    // at wait cycle d (d >= TO means the PIT stays silent).
    task automatic send_pkt(input logic [PW-1:0] p, input logic [MW-1:0] m,
                            input int d, input bit rej,
                            input logic [EW-1:0] e, input bit it);
        bit   ok;
        fwd_t f;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_prefix = p;
        in_metadata = m;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_prefix = {$urandom, $urandom};
        in_metadata = MW'($urandom);
        if (m[MW-1]) begin
            note_drop();
            @(negedge clk);
            chk("rsvd_no_strobe", prefix_ready, 0);
            chk("rsvd_in_ready", in_ready, 1);
        end else begin
            pit_in_bit = 1'b1;
            rejected = 1'($urandom_range(0, 1));
            table_entry = EW'($urandom);
            interest_packet = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("issue_strobe", prefix_ready, 1);
            chk("issue_prefix", FIB_to_PIT_prefix, p);
            chk("issue_meta", FIB_to_PIT_metadata, 64'(m));
            for (int k = 0; k < TO; k++) begin
                @(posedge clk); #1;
                if (k == d) begin
                    pit_in_bit = 1'b1;
                    rejected = rej;
                    table_entry = e;
                    interest_packet = it;
                end else begin
                    pit_in_bit = 1'b0;
                    rejected = 1'b0;
                    table_entry = EW'($urandom);
                    interest_packet = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                chk("wait_no_strobe", prefix_ready, 0);
                chk("wait_prefix", FIB_to_PIT_prefix, p);
                chk("timeout_err", timeout_err, 64'((k == TO - 1) && (d >= TO)));
                if (k == d) break;
            end
            @(posedge clk); #1;
            pit_in_bit = 1'b0;
            rejected = 1'b0;
            if (d < TO && !rej) begin
                f.p = p;
                f.e = e;
                f.i = it;
                exp_q.push_back(f);
                @(negedge clk);
                chk("fwd_latency", fwd_valid, 1);
            end else begin
                note_drop();
                @(negedge clk);
                chk("drop_no_fwd", fwd_valid, 0);
                chk("drop_in_ready", in_ready, 1);
                chk("drop_no_tmo", timeout_err, 0);
            end
        end
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("idle_return", 64'(ok), 1);
        chk("drop_count", drop_count, 64'(exp_drops));
    endtask

    // Random downstream backpressure
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) fwd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on each downstream transfer
    fwd_t prev;
    fwd_t got;
    bit   stalled = 0;
    always @(negedge clk) begin
        if (!mon_en) begin
            stalled = 0;
        end else if (fwd_valid) begin
            chk("fwd_in_ready_low", in_ready, 0);
            if (stalled) begin
                chk("stall_prefix", fwd_prefix, prev.p);
                chk("stall_entry", 64'(fwd_entry), 64'(prev.e));
                chk("stall_intr", 64'(fwd_is_interest), 64'(prev.i));
            end
            prev.p = fwd_prefix;
            prev.e = fwd_entry;
            prev.i = fwd_is_interest;
            if (fwd_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL fwd_unexpected: got prefix %0h expected none", fwd_prefix);
                end else begin
                    got = exp_q.pop_front();
                    if (fwd_prefix !== got.p || fwd_entry !== got.e ||
                        fwd_is_interest !== got.i) begin
                        n_err++;
                        $display("FAIL fwd_data: got %0h/%0h/%0b expected %0h/%0h/%0b",
                                 fwd_prefix, fwd_entry, fwd_is_interest, got.p, got.e, got.i);
                    end
                end
                stalled = 0;
            end else begin
                stalled = 1;
            end
        end else begin
            if (stalled) begin
                n_chk++;
                n_err++;
                $display("FAIL fwd_withdrawn: got fwd_valid 0 expected 1");
            end
            stalled = 0;
        end
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // T1 reset
        rst = 1'b0;
        in_valid = 1'b1;
        in_prefix = 64'h1234;
        in_metadata = 8'h01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_strobe", prefix_ready, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_pit_prefix", FIB_to_PIT_prefix, 0);
        chk("rst_fwd_entry", 64'(fwd_entry), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rel_in_ready_0", in_ready, 0);
        @(negedge clk);
        chk("rel_in_ready_1", in_ready, 1);
        mon_en = 1;

        // T2 hit
        send_pkt(64'h24FDBF80A6EF7DA7, 8'h3F, 0, 0, 11'h2A5, 0);
        // T3 reject with pit_in_bit also high
        send_pkt(64'hA5A5_0000_1111_2222, 8'h41, 0, 1, 11'h011, 1);
        // T4 silent PIT
        send_pkt(64'h0BAD_F00D_0000_0001, 8'h10, 99, 0, 11'h000, 0);
        // late hit on the last wait cycle
        send_pkt(64'h7777_6666_5555_4444, 8'h45, TO - 1, 0, 11'h7FF, 1);
        // T6 reserved type
        send_pkt(64'hFEED_FACE_0000_0002, 8'hBF, 0, 0, 11'h000, 0);

        // T5 backpressure
        fwd_ready = 1'b0;
        fork
            send_pkt(64'hC0FF_EE00_1234_5678, 8'h42, 1, 0, 11'h155, 1);
            begin
                repeat (11) @(posedge clk);
                #1 fwd_ready = 1'b1;
                @(posedge clk);
                #1 fwd_ready = 1'b0;
            end
        join
        fwd_ready = 1'b1;

        // Random traffic
        rand_rdy = 1;
        for (int i = 0; i < 60; i++) begin
            send_pkt({$urandom, $urandom}, MW'($urandom),
                     int'($urandom_range(0, 10)), ($urandom_range(0, 2) == 0),
                     EW'($urandom), 1'($urandom_range(0, 1)));
        end
        rand_rdy = 0;
        fwd_ready = 1'b1;
        repeat (4) @(posedge clk);

        // T6 saturation
        #1;
        in_valid = 1'b1;
        in_metadata = 8'hC0;
        n = 65535 - exp_drops + 3;
        repeat (n) @(posedge clk);
        #1 in_valid = 1'b0;
        exp_drops = 65535;
        @(negedge clk);
        chk("drop_saturate", drop_count, 16'hFFFF);
        chk("sat_no_strobe", prefix_ready, 0);
        send_pkt(64'h5A5A_5A5A_5A5A_5A5A, 8'h01, 99, 0, 11'h000, 0);

        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
